// File: rtl/testbasic6_writer.sv
// Producer for the TestBasic6 blocking inputs: alternates counter-derived values on b_out / b_out2.
// Optional stall counter output is enabled by defining TESTBASIC6_WRITER_STALL_CNT_EN.
//
// state      | meaning
// SEC_SEND1  | offering var on b_out, waiting for b_out_sync
// SEC_SEND2  | offering var<<1 on b_out2, waiting for b_out2_sync
// SEC_DONE   | NUM_PAIRS pairs sent, all channels idle until reset
module testbasic6_writer #(
    parameter logic [31:0] START_VAL = 32'd4,
    parameter logic [31:0] STEP      = 32'd1,
    parameter logic [31:0] NUM_PAIRS = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] b_out,
    input  logic        b_out_sync,
    output logic        b_out_notify,
    output logic [31:0] b_out2,
    input  logic        b_out2_sync,
    output logic        b_out2_notify,
`ifdef TESTBASIC6_WRITER_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        done
);

    typedef enum logic [1:0] {
        SEC_SEND1 = 2'd0,
        SEC_SEND2 = 2'd1,
        SEC_DONE  = 2'd2
    } section_t;

    section_t    section;
    section_t    section_nxt;
    logic [31:0] count_val;
    logic [31:0] pairs;
    logic        xfer1;
    logic        xfer2;
    logic        last_pair;

    assign xfer1     = (section == SEC_SEND1) && b_out_sync;
    assign xfer2     = (section == SEC_SEND2) && b_out2_sync;
    assign last_pair = (NUM_PAIRS != 32'd0) && ((pairs + 32'd1) == NUM_PAIRS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section <= SEC_SEND1;
        end else begin
            section <= section_nxt;
        end
    end

    always_comb begin
        section_nxt = section;
        case (section)
            SEC_SEND1: if (xfer1) section_nxt = SEC_SEND2;
            SEC_SEND2: if (xfer2) section_nxt = last_pair ? SEC_DONE : SEC_SEND1;
            SEC_DONE:  section_nxt = SEC_DONE;
            default:   section_nxt = SEC_SEND1;
        endcase
    end

    always_comb begin
        b_out_notify  = 1'b0;
        b_out2_notify = 1'b0;
        done          = 1'b0;
        case (section)
            SEC_SEND1: b_out_notify  = 1'b1;
            SEC_SEND2: b_out2_notify = 1'b1;
            SEC_DONE:  done          = 1'b1;
            default:   b_out_notify  = 1'b0;
        endcase
    end

    // Data registers only change on a transfer edge, so each value is stable while its notify is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_val <= START_VAL;
            pairs     <= 32'd0;
            b_out     <= START_VAL;
            b_out2    <= 32'd0;
        end else begin
            if (xfer1) begin
                b_out2 <= count_val << 1;
            end
            if (xfer2) begin
                pairs     <= pairs + 32'd1;
                count_val <= count_val + STEP;
                if (!last_pair) begin
                    b_out <= count_val + STEP;
                end
            end
        end
    end

`ifdef TESTBASIC6_WRITER_STALL_CNT_EN
    logic stalled;

    assign stalled = ((section == SEC_SEND1) && !b_out_sync) ||
                     ((section == SEC_SEND2) && !b_out2_sync);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (stalled && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
